matmul_nxn_mac: RTL and testbench
=================================

Name: matmul_nxn_mac

Overview:
- Parametrised successor to the fixed 2x2 matrix multiplier: computes C = A x B, or C = C_prev + A x B, for unsigned N x N matrices.
- Uses N*N MAC cells iterating over k, one k per cycle, so latency scales with N.
- valid/ready handshakes on both input and output replace the start/done strobes.
- Optional saturation and per-job overflow reporting.
- Sits in the placement/routability puzzle designs as the dense arithmetic core.

Parameters:
- N, 2, matrix dimension (legal 2..4).
- DATA_W, 8, unsigned element width of A and B.
- OUT_W, 16, unsigned element width of C (legal >= 2*DATA_W).
- SATURATE, 0, 1 clamps overflowing elements to all-ones; 0 wraps (keeps low OUT_W bits).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  block accepts a job.
- accumulate  in  1  sampled with job: add product to held C.
- a_flat  in  N*N*DATA_W  A; element (i,k) at bits (i*N+k)*DATA_W +: DATA_W.
- b_flat  in  N*N*DATA_W  B; same packing, element (k,j).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- c_flat  out  N*N*OUT_W  C; element (i,j) at (i*N+j)*OUT_W +: OUT_W.
- overflow  out  1  OR over elements of this job's overflow; valid with out_valid.
- busy  out  1  high in COMPUTE or RESULT.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, overflow=0.
  - c_flat=0; all accumulators and the k counter cleared.
  - Reset has priority over every other event, including mid-COMPUTE and mid-RESULT; the job in flight is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready (cycle T): register a_flat, b_flat and accumulate; set k=0.
  - Init accumulators: zero-extended held C if accumulate=1, else 0.
  - Go to COMPUTE.
- COMPUTE:
  - in_ready=0.
  - Each cycle, every cell (i,j): acc += a(i,k)*b(k,j); k increments.
  - After the k=N-1 cycle, go to RESULT.
  - N cycles, T+1..T+N.
- RESULT:
  - out_valid=1 from cycle T+N+1. c_flat and overflow are updated in the same edge that enters RESULT.
  - Stay in RESULT while out_ready=0; c_flat, overflow and out_valid remain stable.
  - On out_valid&out_ready: go to IDLE; out_valid=0 the next cycle.
  - c_flat keeps its value after the handshake; it is the held C for a later accumulate job.
- Arithmetic:
  - Products are 2*DATA_W bits.
  - Accumulator width ACC_W = OUT_W + clog2(N) + 1, so no intermediate loss.
  - Element overflow when the final acc >= 2^OUT_W.
  - SATURATE=1: element = 2^OUT_W-1. SATURATE=0: element = acc[OUT_W-1:0].
  - The next accumulate job adds to the stored (saturated or wrapped) value.
- Boundaries:
  - accumulate on the first job after reset adds to 0.
  - in_valid during COMPUTE/RESULT is ignored (in_ready=0); the upstream holds the job.
  - in_valid and accumulate are don't-care while in_ready=0.
  - No input bypass: at most one job in flight.

Decomposition:
- Package matmul_pkg:
  - state enum {IDLE, COMPUTE, RESULT}.
  - clog2 function and ACC_W derivation.
  - Index helper functions for flat-bus element slicing.
- Sub-module matmul_mac_cell, instantiated N*N times:
  - load (init value), mac_en, a/b operands, acc output.
  - Saturation/wrap and overflow bit per cell.
- Top holds FSM, k counter, operand registers, output handshake.

Test Plan:
- N=2, DATA_W=8, OUT_W=16: A=[[1,2],[3,4]], B=[[5,6],[7,8]], accumulate=0 -> C=[[19,22],[43,50]], overflow=0, out_valid exactly 3 cycles after the accept edge.
- Same job repeated with accumulate=1 -> C=[[38,44],[86,100]], overflow=0.
- All elements 255, accumulate=0 -> every sum 130050 >= 65536, overflow=1:
  - SATURATE=0 -> each c=64514.
  - SATURATE=1 -> each c=65535.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> c_flat/overflow stable, in_ready=0, a concurrent in_valid is not accepted; out_ready=1 -> IDLE next cycle, then the pending job is accepted.
- rst_n low for 1 cycle during the second COMPUTE cycle -> next cycle: out_valid=0, in_ready=1, c_flat=0. A following accumulate=1 job with A=[[1,2],[3,4]], B=[[5,6],[7,8]] gives [[19,22],[43,50]].
- N=3: A=identity, B=[[1,2,3],[4,5,6],[7,8,9]] -> C=B, out_valid 4 cycles after accept; back-to-back jobs with out_ready tied high are accepted every 5 cycles.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and elaboration helpers for the N x N MAC matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESULT  = 2'd2
    } state_t;

    // Ceiling log2; only used on elaboration-time constants.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Worst case is held C plus N full-scale products, which fits in this width.
    function automatic int acc_width(input int out_w, input int n);
        return out_w + clog2(n) + 1;
    endfunction

    // k counter needs at least one bit even when clog2 would give zero.
    function automatic int k_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // Low bit of element (row, col) in a row-major flat bus of w-bit elements.
    function automatic int elem_lo(input int row, input int col, input int n, input int w);
        return (row * n + col) * w;
    endfunction

endpackage

// File: rtl/matmul_mac_cell.sv
// One output element: accumulates a*b per k step, then latches the
// saturated or wrapped result and its overflow flag.
module matmul_mac_cell
    import matmul_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 16,
    parameter int ACC_W    = 18,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_keep,
    input  logic              i_mac_en,
    input  logic              i_last,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [OUT_W-1:0]  o_c,
    output logic              o_ovf
);

    logic [ACC_W-1:0]    r_acc;
    logic [OUT_W-1:0]    r_c;
    logic                r_ovf;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_sum;
    logic                w_ovf;
    logic [OUT_W-1:0]    w_res;

    assign w_prod = {{DATA_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_b};
    assign w_sum  = r_acc + {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
    assign w_ovf  = |w_sum[ACC_W-1:OUT_W];
    assign w_res  = ((SATURATE != 0) && w_ovf) ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];

    // Load seeds the accumulator from the held C; the last k step also commits C.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
        end else if (i_load) begin
            r_acc <= i_keep ? {{(ACC_W-OUT_W){1'b0}}, r_c} : '0;
        end else if (i_mac_en) begin
            r_acc <= w_sum;
            if (i_last) begin
                r_c   <= w_res;
                r_ovf <= w_ovf;
            end
        end
    end

    assign o_c   = r_c;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/matmul_nxn_mac.sv
// N x N unsigned matrix multiply/accumulate: one k per cycle over an
// N*N array of MAC cells, valid/ready on both sides, one job in flight.
module matmul_nxn_mac
    import matmul_pkg::*;
#(
    parameter int N        = 2,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    accumulate,
    input  logic [N*N*DATA_W-1:0]   a_flat,
    input  logic [N*N*DATA_W-1:0]   b_flat,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N*N*OUT_W-1:0]    c_flat,
    output logic                    overflow,
    output logic                    busy
);

    localparam int ACC_W = acc_width(OUT_W, N);
    localparam int KW    = k_width(N);

    state_t                          r_state, w_next;
    logic [N*N*DATA_W-1:0]           r_a, r_b;
    logic [KW-1:0]                   r_k;
    logic                            w_accept, w_mac_en, w_last;
    logic [N-1:0][DATA_W-1:0]        w_a_op, w_b_op;
    logic [N*N-1:0][OUT_W-1:0]       w_c;
    logic [N*N-1:0]                  w_ovf;

    // State register; reset discards any job in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state and handshake/control decode.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_mac_en  = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = COMPUTE;
                end
            end
            COMPUTE: begin
                busy     = 1'b1;
                w_mac_en = 1'b1;
                if (r_k == KW'(N-1)) begin
                    w_last = 1'b1;
                    w_next = RESULT;
                end
            end
            RESULT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand capture on accept; k holds at N-1 after the last step so it never indexes past the matrix.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_k <= '0;
        end else if (w_accept) begin
            r_a <= a_flat;
            r_b <= b_flat;
            r_k <= '0;
        end else if (w_mac_en && !w_last) begin
            r_k <= r_k + KW'(1);
        end
    end

    // Column k of A feeds every row, row k of B feeds every column.
    always_comb begin
        w_a_op = '0;
        w_b_op = '0;
        for (int i = 0; i < N; i++) begin
            w_a_op[i] = r_a[elem_lo(i, int'(r_k), N, DATA_W) +: DATA_W];
            w_b_op[i] = r_b[elem_lo(int'(r_k), i, N, DATA_W) +: DATA_W];
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            matmul_mac_cell #(
                .DATA_W   (DATA_W),
                .OUT_W    (OUT_W),
                .ACC_W    (ACC_W),
                .SATURATE (SATURATE)
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .i_load   (w_accept),
                .i_keep   (accumulate),
                .i_mac_en (w_mac_en),
                .i_last   (w_last),
                .i_a      (w_a_op[gi]),
                .i_b      (w_b_op[gj]),
                .o_c      (w_c[gi*N+gj]),
                .o_ovf    (w_ovf[gi*N+gj])
            );
        end
    end

    // Packed index gi*N+gj lands exactly on the row-major element slot.
    assign c_flat   = w_c;
    assign overflow = |w_ovf;

endmodule

// File: tb/tb_matmul_nxn_mac.sv
// Scoreboard bench: dut0 is N=2 wrapping, dut1 is N=3 saturating.
module tb_matmul_nxn_mac;

    typedef struct {
        logic [255:0] c;
        bit           ovf;
        int           tacc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         iv0, ir0, ac0, ov0, or0, of0, bz0;
    logic [31:0]  a0, b0;
    logic [63:0]  c0;
    logic         iv1, ir1, ac1, ov1, or1, of1, bz1;
    logic [71:0]  a1, b1;
    logic [143:0] c1;

    matmul_nxn_mac #(.N(2), .DATA_W(8), .OUT_W(16), .SATURATE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .accumulate(ac0),
        .a_flat(a0), .b_flat(b0), .out_valid(ov0), .out_ready(or0), .c_flat(c0),
        .overflow(of0), .busy(bz0));

    matmul_nxn_mac #(.N(3), .DATA_W(8), .OUT_W(16), .SATURATE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .accumulate(ac1),
        .a_flat(a1), .b_flat(b1), .out_valid(ov1), .out_ready(or1), .c_flat(c1),
        .overflow(of1), .busy(bz1));

    exp_t   q0[$];
    exp_t   q1[$];
    longint held[2][16];
    int     total = 0;
    int     bad = 0;
    int     cyc = 0;
    int     last_acc[2];
    int     pop_cyc[2];
    bit     prev_ov[2];
    bit     rdone;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain matrix arithmetic on integers, then clamp or wrap.
    function automatic exp_t model(input int d, input logic [127:0] a, input logic [127:0] b,
                                   input bit acc, input int t);
        exp_t   e;
        longint s;
        int     n;
        n = (d == 0) ? 2 : 3;
        e.c = '0;
        e.ovf = 1'b0;
        e.tacc = t;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = acc ? held[d][i*n+j] : 0;
                for (int k = 0; k < n; k++)
                    s += longint'(a[(i*n+k)*8 +: 8]) * longint'(b[(k*n+j)*8 +: 8]);
                if (s >= 65536) begin
                    e.ovf = 1'b1;
                    s = (d == 1) ? 65535 : s % 65536;
                end
                held[d][i*n+j] = s;
                e.c[(i*n+j)*16 +: 16] = s[15:0];
            end
        end
        return e;
    endfunction

    task automatic send(input int d, input logic [127:0] a, input logic [127:0] b, input bit acc);
        int t = 0;
        if (d == 0) begin a0 = a[31:0]; b0 = b[31:0]; ac0 = acc; iv0 = 1'b1; end
        else        begin a1 = a[71:0]; b1 = b[71:0]; ac1 = acc; iv1 = 1'b1; end
        @(negedge clk);
        while (!((d == 0) ? ir0 : ir1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!((d == 0) ? ir0 : ir1)) begin
            chk("accept_timeout", (d == 0) ? ir0 : ir1, 1);
        end else begin
            if (d == 0) q0.push_back(model(d, a, b, acc, cyc));
            else        q1.push_back(model(d, a, b, acc, cyc));
            last_acc[d] = cyc;
        end
        @(posedge clk);
        #1;
        if (d == 0) iv0 = 1'b0; else iv1 = 1'b0;
    endtask

    task automatic mon(input int d);
        logic         ov, rd, ir, bz, of;
        logic [255:0] c;
        exp_t         e;
        int           sz;
        if (d == 0) begin ov = ov0; rd = or0; ir = ir0; bz = bz0; of = of0; c = 256'(c0); sz = q0.size(); end
        else        begin ov = ov1; rd = or1; ir = ir1; bz = bz1; of = of1; c = 256'(c1); sz = q1.size(); end
        if (!rst_n) begin
            prev_ov[d] = 1'b0;
            return;
        end
        if (ov) begin
            if (sz == 0) begin
                chk("unexpected_out_valid", ov, 0);
            end else begin
                if (d == 0) e = q0[0]; else e = q1[0];
                if (!prev_ov[d]) chk("latency", cyc - e.tacc, (d == 0) ? 3 : 4);
                chk("c_flat", c, e.c);
                chk("overflow", of, e.ovf);
                chk("in_ready_in_result", ir, 0);
                chk("busy_in_result", bz, 1);
                if (rd) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    pop_cyc[d] = cyc;
                end
            end
        end
        prev_ov[d] = ov;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic drain(input int d);
        int t = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", (d == 0) ? q0.size() : q1.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench hung");
    end

    initial begin
        logic [127:0] ma, mb, ra, rb;
        logic [255:0] ev;
        int           p;
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) held[d][i] = 0;
        rst_n = 1'b0;
        iv0 = 0; ac0 = 0; a0 = '0; b0 = '0; or0 = 1'b1;
        iv1 = 0; ac1 = 0; a1 = '0; b1 = '0; or1 = 1'b1;
        rdone = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", ir0, 1);
        chk("rst_out_valid", ov0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_overflow", of0, 0);
        chk("rst_c0", c0, 0);
        chk("rst_c1", c1, 0);
        @(posedge clk);
        #1;

        // Basic job, then the same job accumulated on top.
        ma = 128'({8'd4, 8'd3, 8'd2, 8'd1});
        mb = 128'({8'd8, 8'd7, 8'd6, 8'd5});
        send(0, ma, mb, 1'b0);
        drain(0);
        chk("basic_c", c0, {16'd50, 16'd43, 16'd22, 16'd19});
        send(0, ma, mb, 1'b1);
        drain(0);
        chk("accum_c", c0, {16'd100, 16'd86, 16'd44, 16'd38});

        // All-ones overflow with wrap.
        send(0, '1, '1, 1'b0);
        drain(0);
        chk("wrap_c", c0, {4{16'd64514}});
        chk("wrap_ovf", of0, 1);

        // Backpressure with a pending job held upstream.
        or0 = 1'b0;
        send(0, ma, mb, 1'b0);
        p = 0;
        while (!ov0 && p < 50) begin @(negedge clk); p++; end
        chk("bp_out_valid_seen", ov0, 1);
        @(posedge clk);
        #1;
        fork
            send(0, mb, ma, 1'b1);
            begin
                repeat (5) @(posedge clk);
                #1 or0 = 1'b1;
            end
        join
        chk("pending_accept_gap", last_acc[0] - pop_cyc[0], 1);
        drain(0);

        // Reset in the second compute cycle discards the job.
        send(0, '1, '1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        q0.delete();
        for (int d = 0; d < 2; d++) for (int i = 0; i < 16; i++) held[d][i] = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", ov0, 0);
        chk("midrst_in_ready", ir0, 1);
        chk("midrst_c", c0, 0);
        @(posedge clk);
        #1;
        send(0, ma, mb, 1'b1);
        drain(0);
        chk("post_rst_accum_c", c0, {16'd50, 16'd43, 16'd22, 16'd19});

        // Random jobs under random backpressure.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    ra = {$urandom, $urandom, $urandom, $urandom};
                    rb = {$urandom, $urandom, $urandom, $urandom};
                    if ($urandom_range(0, 3) == 0) ra = '1;
                    if ($urandom_range(0, 3) == 0) rb = '1;
                    send(0, ra, rb, 1'($urandom_range(0, 1)));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk);
                    #1 or0 = ($urandom_range(0, 3) != 0);
                end
                or0 = 1'b1;
            end
        join
        drain(0);

        // N=3: identity times B, back-to-back with out_ready held high.
        ma = '0;
        mb = '0;
        ev = '0;
        for (int i = 0; i < 3; i++) ma[(i*3+i)*8 +: 8] = 8'd1;
        for (int i = 0; i < 9; i++) begin
            mb[i*8 +: 8] = 8'(i + 1);
            ev[i*16 +: 16] = 16'(i + 1);
        end
        for (int r = 0; r < 3; r++) begin
            p = last_acc[1];
            send(1, ma, mb, 1'b0);
            if (r > 0) chk("b2b_gap", last_acc[1] - p, 5);
        end
        drain(1);
        chk("identity_c", 256'(c1), ev);

        // N=3 saturation, then an accumulate onto the clamped value.
        send(1, '1, '1, 1'b0);
        drain(1);
        chk("sat_c", 256'(c1), 256'({144{1'b1}}));
        chk("sat_ovf", of1, 1);
        send(1, ma, mb, 1'b1);
        for (int i = 0; i < 10; i++) begin
            ra = {$urandom, $urandom, $urandom, $urandom};
            rb = {$urandom, $urandom, $urandom, $urandom};
            if (i % 3 == 0) ra = ra >> 64;
            send(1, ra, rb, 1'($urandom_range(0, 1)));
        end
        drain(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
